// File: rtl/lcd_strobe_timer.sv
// rtl/lcd_strobe_timer.sv - LCD E strobe generator: free-running period tick plus SETUP/PULSE/HOLD sequencer.
// Strobes start on Tick (Mode=0) or Req (Mode=1); a start can coincide with the previous strobe's end.
module lcd_strobe_timer #(
  parameter int PERIOD = 4000,
  parameter int SETUP  = 6,
  parameter int PULSE  = 56,
  parameter int HOLD   = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Mode,
  input  logic Req,
  input  logic Clr,
  output logic Tick,
  output logic Enable,
  output logic Busy,
  output logic Ack,
  output logic Done,
  output logic Overrun
);

  localparam int PW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SP_MAX  = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int SEQ_MAX = (SP_MAX > HOLD) ? SP_MAX : HOLD;
  localparam int SW      = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
  localparam logic [SW-1:0] SETUP_LAST  = SW'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [SW-1:0] PULSE_LAST  = SW'((PULSE > 0) ? PULSE - 1 : 0);
  localparam logic [SW-1:0] HOLD_LAST   = SW'((HOLD > 0) ? HOLD - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   period_cnt_q, period_cnt_d;
  logic [SW-1:0]   seq_cnt_q, seq_cnt_d;
  logic            tick_q, tick_d;
  logic            enable_q, enable_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;
  logic            mode_q, mode_d;
  logic            can_start;
  logic            strobe_end;
  logic            start_evt;

  always_comb begin
    period_cnt_d = period_cnt_q + PW'(1);
    tick_d       = 1'b0;
    if (period_cnt_q == PERIOD_LAST) begin
      period_cnt_d = '0;
      tick_d       = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_cnt_d  = seq_cnt_q;
    enable_d   = enable_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    mode_d     = mode_q;
    overrun_d  = overrun_q;
    can_start  = 1'b0;
    strobe_end = 1'b0;
    start_evt  = Mode ? Req : tick_q;

    case (state_q)
      ST_IDLE: can_start = 1'b1;
      ST_SETUP: begin
        if (seq_cnt_q == SETUP_LAST) begin
          state_d   = ST_PULSE;
          seq_cnt_d = '0;
          enable_d  = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + SW'(1);
        end
      end
      ST_PULSE: begin
        if (seq_cnt_q == PULSE_LAST) begin
          enable_d  = 1'b0;
          seq_cnt_d = '0;
          if (HOLD > 0) begin
            state_d = ST_HOLD;
          end else begin
            strobe_end = 1'b1;
          end
        end else begin
          seq_cnt_d = seq_cnt_q + SW'(1);
        end
      end
      ST_HOLD: begin
        if (seq_cnt_q == HOLD_LAST) begin
          seq_cnt_d  = '0;
          strobe_end = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The last edge of a strobe doubles as the first IDLE sample, giving back-to-back strobes.
    if (strobe_end) begin
      done_d    = 1'b1;
      state_d   = ST_IDLE;
      can_start = 1'b1;
    end

    if (can_start && start_evt) begin
      mode_d    = Mode;
      ack_d     = Mode;
      seq_cnt_d = '0;
      if (SETUP > 0) begin
        state_d = ST_SETUP;
      end else begin
        state_d  = ST_PULSE;
        enable_d = 1'b1;
      end
    end

    // Overrun is judged against the mode the running strobe was started in; set beats clear.
    if (Clr) begin
      overrun_d = 1'b0;
    end
    if (tick_q && !can_start && (state_q != ST_IDLE) && !mode_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      seq_cnt_q    <= '0;
      tick_q       <= 1'b0;
      enable_q     <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      seq_cnt_q    <= seq_cnt_d;
      tick_q       <= tick_d;
      enable_q     <= enable_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      mode_q       <= mode_d;
    end
  end

  assign Tick    = tick_q;
  assign Enable  = enable_q;
  assign Busy    = (state_q != ST_IDLE);
  assign Ack     = ack_q;
  assign Done    = done_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_lcd_strobe_timer.sv
// tb/tb_lcd_strobe_timer.sv - scoreboard bench for lcd_strobe_timer across three parameter sets.
// Expected output events (kind, edge number) are queued by stimulus and consumed by a negedge monitor.
module tb_lcd_strobe_timer;

  localparam int K_TICK = 0, K_ACK = 1, K_DONE = 2, K_EN_R = 3, K_EN_F = 4;
  localparam int K_BUSY_R = 5, K_BUSY_F = 6, K_OVR_R = 7, K_OVR_F = 8;

  typedef struct {
    int d;
    int k;
    int e;
  } ev_t;

  logic       Clk = 1'b0;
  logic [2:0] rst = 3'b000;
  logic [2:0] mode = 3'b000;
  logic [2:0] req = 3'b000;
  logic [2:0] clr = 3'b000;
  logic [2:0] tick_w, en_w, busy_w, ack_w, done_w, ovr_w;
  logic [2:0] prev_en = 3'b000, prev_busy = 3'b000, prev_ovr = 3'b000;
  int         ec [3];
  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q [$];
  string      kname [0:8] = '{"tick", "ack", "done", "en_rise", "en_fall",
                              "busy_rise", "busy_fall", "ovr_rise", "ovr_fall"};

  always #5 Clk = ~Clk;

  lcd_strobe_timer #(.PERIOD(20), .SETUP(2), .PULSE(5), .HOLD(3)) dut_a (
    .Clk(Clk), .Reset(rst[0]), .Mode(mode[0]), .Req(req[0]), .Clr(clr[0]),
    .Tick(tick_w[0]), .Enable(en_w[0]), .Busy(busy_w[0]), .Ack(ack_w[0]),
    .Done(done_w[0]), .Overrun(ovr_w[0]));

  lcd_strobe_timer #(.PERIOD(8), .SETUP(2), .PULSE(5), .HOLD(3)) dut_b (
    .Clk(Clk), .Reset(rst[1]), .Mode(mode[1]), .Req(req[1]), .Clr(clr[1]),
    .Tick(tick_w[1]), .Enable(en_w[1]), .Busy(busy_w[1]), .Ack(ack_w[1]),
    .Done(done_w[1]), .Overrun(ovr_w[1]));

  lcd_strobe_timer #(.PERIOD(20), .SETUP(0), .PULSE(1), .HOLD(0)) dut_c (
    .Clk(Clk), .Reset(rst[2]), .Mode(mode[2]), .Req(req[2]), .Clr(clr[2]),
    .Tick(tick_w[2]), .Enable(en_w[2]), .Busy(busy_w[2]), .Ack(ack_w[2]),
    .Done(done_w[2]), .Overrun(ovr_w[2]));

  always @(posedge Clk) begin
    for (int d = 0; d < 3; d++) begin
      ec[d] <= rst[d] ? ec[d] + 1 : 0;
    end
  end

  task automatic push(input int d, input int k, input int e);
    ev_t ev;
    ev.d = d;
    ev.k = k;
    ev.e = e;
    exp_q.push_back(ev);
  endtask

  task automatic check_ev(input int d, input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].d == d && exp_q[i].k == k) idx = i;
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL unexpected_%s dut%0d: seen after edge %0d, required none", kname[k], d, ec[d]);
    end else begin
      if (exp_q[idx].e != ec[d]) begin
        failures++;
        $display("FAIL %s dut%0d: seen after edge %0d, required after edge %0d",
                 kname[k], d, ec[d], exp_q[idx].e);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge Clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        if (tick_w[d]) check_ev(d, K_TICK);
        if (ack_w[d]) check_ev(d, K_ACK);
        if (done_w[d]) check_ev(d, K_DONE);
        if (en_w[d] && !prev_en[d]) check_ev(d, K_EN_R);
        if (!en_w[d] && prev_en[d]) check_ev(d, K_EN_F);
        if (busy_w[d] && !prev_busy[d]) check_ev(d, K_BUSY_R);
        if (!busy_w[d] && prev_busy[d]) check_ev(d, K_BUSY_F);
        if (ovr_w[d] && !prev_ovr[d]) check_ev(d, K_OVR_R);
        if (!ovr_w[d] && prev_ovr[d]) check_ev(d, K_OVR_F);
      end
      prev_en[d]   <= rst[d] & en_w[d];
      prev_busy[d] <= rst[d] & busy_w[d];
      prev_ovr[d]  <= rst[d] & ovr_w[d];
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic wait_ec(input int d, input int n);
    int guard;
    guard = 0;
    while (ec[d] < n && guard < 500) begin
      @(negedge Clk);
      guard++;
    end
    if (ec[d] < n) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d: reached edge %0d, required edge %0d", d, ec[d], n);
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b0;
    #1;
    chk("reset_tick", tick_w[d], 1'b0);
    chk("reset_enable", en_w[d], 1'b0);
    chk("reset_busy", busy_w[d], 1'b0);
    chk("reset_ack", ack_w[d], 1'b0);
    chk("reset_done", done_w[d], 1'b0);
    chk("reset_overrun", ovr_w[d], 1'b0);
    repeat (3) @(negedge Clk);
    rst[d] = 1'b1;
  endtask

  initial begin
    // Mode=0 free-run strobes on dut_a
    do_reset(0);
    push(0, K_TICK, 20); push(0, K_TICK, 40); push(0, K_TICK, 60); push(0, K_TICK, 80);
    for (int i = 0; i < 4; i++) begin
      push(0, K_BUSY_R, 21 + 20 * i);
      push(0, K_EN_R, 23 + 20 * i);
    end
    for (int i = 0; i < 3; i++) begin
      push(0, K_EN_F, 28 + 20 * i);
      push(0, K_BUSY_F, 31 + 20 * i);
      push(0, K_DONE, 31 + 20 * i);
    end
    wait_ec(0, 84);
    chk("mid_pulse_enable_high", en_w[0], 1'b1);
    do_reset(0);
    push(0, K_TICK, 20); push(0, K_BUSY_R, 21); push(0, K_EN_R, 23);
    wait_ec(0, 1);
    chk("restart_no_done", done_w[0], 1'b0);
    chk("restart_no_tick", tick_w[0], 1'b0);
    wait_ec(0, 24);

    // Mode=1 back-to-back, then a Mode change mid-strobe on dut_a
    mode[0] = 1'b1;
    do_reset(0);
    push(0, K_TICK, 20); push(0, K_TICK, 40);
    push(0, K_ACK, 5); push(0, K_ACK, 15);
    push(0, K_BUSY_R, 5); push(0, K_BUSY_F, 25); push(0, K_BUSY_R, 41); push(0, K_BUSY_F, 51);
    push(0, K_EN_R, 7); push(0, K_EN_R, 17); push(0, K_EN_R, 43);
    push(0, K_EN_F, 12); push(0, K_EN_F, 22); push(0, K_EN_F, 48);
    push(0, K_DONE, 15); push(0, K_DONE, 25); push(0, K_DONE, 51);
    wait_ec(0, 4);
    req[0] = 1'b1;
    wait_ec(0, 20);
    mode[0] = 1'b0;
    wait_ec(0, 22);
    chk("mode1_tick_no_overrun", ovr_w[0], 1'b0);
    wait_ec(0, 30);
    req[0] = 1'b0;
    wait_ec(0, 55);
    rst[0] = 1'b0;

    // Overrun set, clear, and set-beats-clear on dut_b
    do_reset(1);
    for (int i = 1; i <= 5; i++) push(1, K_TICK, 8 * i);
    for (int i = 0; i < 3; i++) begin
      push(1, K_BUSY_R, 9 + 16 * i);
      push(1, K_EN_R, 11 + 16 * i);
    end
    for (int i = 0; i < 2; i++) begin
      push(1, K_EN_F, 16 + 16 * i);
      push(1, K_BUSY_F, 19 + 16 * i);
      push(1, K_DONE, 19 + 16 * i);
    end
    push(1, K_OVR_R, 17); push(1, K_OVR_F, 20); push(1, K_OVR_R, 33);
    wait_ec(1, 17);
    chk("overrun_set", ovr_w[1], 1'b1);
    wait_ec(1, 19);
    clr[1] = 1'b1;
    wait_ec(1, 20);
    clr[1] = 1'b0;
    chk("overrun_cleared", ovr_w[1], 1'b0);
    wait_ec(1, 32);
    clr[1] = 1'b1;
    wait_ec(1, 33);
    clr[1] = 1'b0;
    chk("overrun_set_beats_clr", ovr_w[1], 1'b1);
    wait_ec(1, 45);
    rst[1] = 1'b0;

    // Boundary parameters and Mode toggle on dut_c
    mode[2] = 1'b1;
    do_reset(2);
    push(2, K_TICK, 20); push(2, K_TICK, 40); push(2, K_ACK, 4);
    foreach (exp_q[i]) ;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = (i == 0) ? 4 : 1 + 20 * i;
      push(2, K_BUSY_R, s); push(2, K_EN_R, s);
      push(2, K_EN_F, s + 1); push(2, K_BUSY_F, s + 1); push(2, K_DONE, s + 1);
    end
    wait_ec(2, 3);
    req[2] = 1'b1;
    wait_ec(2, 4);
    req[2] = 1'b0;
    mode[2] = 1'b0;
    chk("boundary_enable", en_w[2], 1'b1);
    chk("boundary_busy", busy_w[2], 1'b1);
    wait_ec(2, 5);
    chk("boundary_busy_one_cycle", busy_w[2], 1'b0);
    wait_ec(2, 30);
    req[2] = 1'b1;
    wait_ec(2, 33);
    req[2] = 1'b0;
    wait_ec(2, 45);
    rst[2] = 1'b0;

    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d still queued, required 0 (first dut%0d %s at edge %0d)",
               exp_q.size(), exp_q[0].d, kname[exp_q[0].k], exp_q[0].e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
